// File: rtl/be_row_gather.sv
// Row gather ahead of the level-1 butterfly: packs four 8-lane beats into one
// 32-slot group and tracks block boundaries according to the transform size.
module be_row_gather (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_dt_vld,
    input  logic         i_start,
    input  logic         i_inverse,
    input  logic [1:0]   i_transize,
    input  logic [223:0] i_data,
    output logic         o_dt_vld,
    output logic         o_inverse,
    output logic [1:0]   o_transize,
    output logic [27:0]  o_0,
    output logic [27:0]  o_1,
    output logic [27:0]  o_2,
    output logic [27:0]  o_3,
    output logic [27:0]  o_4,
    output logic [27:0]  o_5,
    output logic [27:0]  o_6,
    output logic [27:0]  o_7,
    output logic [27:0]  o_8,
    output logic [27:0]  o_9,
    output logic [27:0]  o_10,
    output logic [27:0]  o_11,
    output logic [27:0]  o_12,
    output logic [27:0]  o_13,
    output logic [27:0]  o_14,
    output logic [27:0]  o_15,
    output logic [27:0]  o_16,
    output logic [27:0]  o_17,
    output logic [27:0]  o_18,
    output logic [27:0]  o_19,
    output logic [27:0]  o_20,
    output logic [27:0]  o_21,
    output logic [27:0]  o_22,
    output logic [27:0]  o_23,
    output logic [27:0]  o_24,
    output logic [27:0]  o_25,
    output logic [27:0]  o_26,
    output logic [27:0]  o_27,
    output logic [27:0]  o_28,
    output logic [27:0]  o_29,
    output logic [27:0]  o_30,
    output logic [27:0]  o_31,
    output logic         o_blk_last,
    output logic         o_err
);

    typedef enum logic {IDLE, GATHER} state_t;

    state_t        state_q;
    logic [1:0]    beat_q;
    logic [4:0]    grp_q;
    logic          inv_q;
    logic [1:0]    size_q;
    logic [223:0]  stage_q [3];
    logic [27:0]   slot_q [32];
    logic [27:0]   slot_d [32];
    logic          vld_q;
    logic          err_q;
    logic          out_inv_q;
    logic [1:0]    out_size_q;
    logic          last_q;
    logic [4:0]    grp_last_idx;
    logic [895:0]  group_raw;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no latch is inferred.
        grp_last_idx = 5'd0;
        case (size_q)
            2'd0:    grp_last_idx = 5'd0;
            2'd1:    grp_last_idx = 5'd1;
            2'd2:    grp_last_idx = 5'd7;
            default: grp_last_idx = 5'd31;
        endcase
        // Beat 3 is taken straight from the input so the group completes on its edge.
        group_raw = {i_data, stage_q[2], stage_q[1], stage_q[0]};
        for (int j = 0; j < 32; j++) begin
            slot_d[j] = group_raw[28*j +: 28];
            if (size_q == 2'd0 && (j % 8) >= 4) begin
                slot_d[j] = '0;
            end
        end
    end

    // NOTE: all state below uses non-blocking assignments so each register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            grp_q      <= '0;
            inv_q      <= 1'b0;
            size_q     <= '0;
            vld_q      <= 1'b0;
            err_q      <= 1'b0;
            out_inv_q  <= 1'b0;
            out_size_q <= '0;
            last_q     <= 1'b0;
            // NOTE: the staging buffer is reset as well, so no stale beat survives a reset.
            for (int i = 0; i < 3; i++) begin
                stage_q[i] <= '0;
            end
            for (int j = 0; j < 32; j++) begin
                slot_q[j] <= '0;
            end
        end else begin
            vld_q <= 1'b0;
            err_q <= 1'b0;
            if (i_dt_vld) begin
                if (i_start) begin
                    // A start always begins a fresh block; flag it if it cut one short.
                    if (state_q == GATHER && (beat_q != 2'd0 || grp_q != 5'd0)) begin
                        err_q <= 1'b1;
                    end
                    state_q    <= GATHER;
                    beat_q     <= 2'd1;
                    grp_q      <= '0;
                    inv_q      <= i_inverse;
                    size_q     <= i_transize;
                    stage_q[0] <= i_data;
                end else if (state_q == GATHER) begin
                    if (beat_q == 2'd3) begin
                        slot_q     <= slot_d;
                        vld_q      <= 1'b1;
                        out_inv_q  <= inv_q;
                        out_size_q <= size_q;
                        last_q     <= (grp_q == grp_last_idx);
                        beat_q     <= 2'd0;
                        if (grp_q == grp_last_idx) begin
                            grp_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            grp_q <= grp_q + 5'd1;
                        end
                    end else begin
                        if (beat_q == 2'd0) stage_q[0] <= i_data;
                        if (beat_q == 2'd1) stage_q[1] <= i_data;
                        if (beat_q == 2'd2) stage_q[2] <= i_data;
                        beat_q <= beat_q + 2'd1;
                    end
                end
            end
        end
    end

    assign o_dt_vld   = vld_q;
    assign o_err      = err_q;
    assign o_inverse  = out_inv_q;
    assign o_transize = out_size_q;
    assign o_blk_last = last_q;

    assign o_0  = slot_q[0];
    assign o_1  = slot_q[1];
    assign o_2  = slot_q[2];
    assign o_3  = slot_q[3];
    assign o_4  = slot_q[4];
    assign o_5  = slot_q[5];
    assign o_6  = slot_q[6];
    assign o_7  = slot_q[7];
    assign o_8  = slot_q[8];
    assign o_9  = slot_q[9];
    assign o_10 = slot_q[10];
    assign o_11 = slot_q[11];
    assign o_12 = slot_q[12];
    assign o_13 = slot_q[13];
    assign o_14 = slot_q[14];
    assign o_15 = slot_q[15];
    assign o_16 = slot_q[16];
    assign o_17 = slot_q[17];
    assign o_18 = slot_q[18];
    assign o_19 = slot_q[19];
    assign o_20 = slot_q[20];
    assign o_21 = slot_q[21];
    assign o_22 = slot_q[22];
    assign o_23 = slot_q[23];
    assign o_24 = slot_q[24];
    assign o_25 = slot_q[25];
    assign o_26 = slot_q[26];
    assign o_27 = slot_q[27];
    assign o_28 = slot_q[28];
    assign o_29 = slot_q[29];
    assign o_30 = slot_q[30];
    assign o_31 = slot_q[31];

endmodule

// File: tb/tb_be_row_gather.sv
// Bench for be_row_gather: directed scenarios plus a random stream, checked
// against a queue-based model of beats, groups and blocks.
module tb_be_row_gather;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         i_dt_vld;
    logic         i_start;
    logic         i_inverse;
    logic [1:0]   i_transize;
    logic [223:0] i_data;
    logic         o_dt_vld;
    logic         o_inverse;
    logic [1:0]   o_transize;
    logic         o_blk_last;
    logic         o_err;
    logic [27:0]  dut_slot [32];

    int n_cmp  = 0;
    int n_fail = 0;
    int pulse_cnt, last_cnt, err_cnt;

    // Reference model state: an open block collects beats in a queue; four make a group.
    bit           m_active;
    int           m_grp;
    logic [1:0]   m_size;
    logic         m_inv;
    logic [223:0] m_beats [$];

    logic         e_vld, e_err, e_inv, e_last;
    logic [1:0]   e_size;
    logic [27:0]  e_slot [32];

    be_row_gather dut (
        .clk(clk), .rst(rst),
        .i_dt_vld(i_dt_vld), .i_start(i_start), .i_inverse(i_inverse),
        .i_transize(i_transize), .i_data(i_data),
        .o_dt_vld(o_dt_vld), .o_inverse(o_inverse), .o_transize(o_transize),
        .o_0(dut_slot[0]),   .o_1(dut_slot[1]),   .o_2(dut_slot[2]),   .o_3(dut_slot[3]),
        .o_4(dut_slot[4]),   .o_5(dut_slot[5]),   .o_6(dut_slot[6]),   .o_7(dut_slot[7]),
        .o_8(dut_slot[8]),   .o_9(dut_slot[9]),   .o_10(dut_slot[10]), .o_11(dut_slot[11]),
        .o_12(dut_slot[12]), .o_13(dut_slot[13]), .o_14(dut_slot[14]), .o_15(dut_slot[15]),
        .o_16(dut_slot[16]), .o_17(dut_slot[17]), .o_18(dut_slot[18]), .o_19(dut_slot[19]),
        .o_20(dut_slot[20]), .o_21(dut_slot[21]), .o_22(dut_slot[22]), .o_23(dut_slot[23]),
        .o_24(dut_slot[24]), .o_25(dut_slot[25]), .o_26(dut_slot[26]), .o_27(dut_slot[27]),
        .o_28(dut_slot[28]), .o_29(dut_slot[29]), .o_30(dut_slot[30]), .o_31(dut_slot[31]),
        .o_blk_last(o_blk_last), .o_err(o_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int groups_per_block(input logic [1:0] s);
        case (s)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 8;
            default: return 32;
        endcase
    endfunction

    function automatic logic [223:0] rnd_beat();
        logic [223:0] d;
        for (int n = 0; n < 8; n++) d[28*n +: 28] = 28'($urandom);
        return d;
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_grp    = 0;
        m_size   = 2'd0;
        m_inv    = 1'b0;
        m_beats.delete();
        e_vld = 0; e_err = 0; e_inv = 0; e_last = 0; e_size = 2'd0;
        for (int j = 0; j < 32; j++) e_slot[j] = '0;
    endtask

    task automatic model_beat(input logic start, input logic inv, input logic [1:0] size,
                              input logic [223:0] data);
        int lane;
        logic [27:0] w;
        if (start) begin
            e_err    = m_active && (m_beats.size() != 0 || m_grp != 0);
            m_active = 1;
            m_grp    = 0;
            m_size   = size;
            m_inv    = inv;
            m_beats.delete();
            m_beats.push_back(data);
        end else if (m_active) begin
            m_beats.push_back(data);
            if (m_beats.size() == 4) begin
                e_vld  = 1;
                e_inv  = m_inv;
                e_size = m_size;
                e_last = (m_grp == groups_per_block(m_size) - 1);
                for (int j = 0; j < 32; j++) begin
                    lane = j % 8;
                    w = m_beats[j / 8][28*lane +: 28];
                    if (m_size == 2'd0 && lane >= 4) w = '0;
                    e_slot[j] = w;
                end
                m_beats.delete();
                if (e_last) begin
                    m_active = 0;
                    m_grp    = 0;
                end else begin
                    m_grp++;
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("o_dt_vld", o_dt_vld, e_vld);
        check("o_err", o_err, e_err);
        check("o_inverse", o_inverse, e_inv);
        check("o_transize", o_transize, e_size);
        check("o_blk_last", o_blk_last, e_last);
        for (int j = 0; j < 32; j++) check($sformatf("o_%0d", j), dut_slot[j], e_slot[j]);
        if (o_dt_vld) pulse_cnt++;
        if (o_dt_vld && o_blk_last) last_cnt++;
        if (o_err) err_cnt++;
    endtask

    task automatic step(input logic vld, input logic start, input logic inv,
                        input logic [1:0] size, input logic [223:0] data);
        i_dt_vld   = vld;
        i_start    = start;
        i_inverse  = inv;
        i_transize = size;
        i_data     = data;
        e_vld = 0;
        e_err = 0;
        if (vld) model_beat(start, inv, size, data);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic gap();
        step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 2'($urandom_range(3)), rnd_beat());
    endtask

    // Non-start beats with noise on mode/size, optionally separated by idle cycles.
    task automatic send_beats(input int n, input int gap_max);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gap_max)) gap();
            step(1'b1, 1'b0, 1'($urandom_range(1)), 2'($urandom_range(3)), rnd_beat());
        end
    endtask

    initial begin
        logic [223:0] d;
        rst = 1'b1;
        i_dt_vld = 0; i_start = 0; i_inverse = 0; i_transize = 0; i_data = '0;
        pulse_cnt = 0; last_cnt = 0; err_cnt = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;

        // 32x32: first group carries lane values 8k+n+1.
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 8; n++) d[28*n +: 28] = 28'(8*k + n + 1);
            step(1'b1, k == 0, 1'b0, 2'd3, d);
        end
        for (int j = 0; j < 32; j++) check($sformatf("sz3_o_%0d", j), dut_slot[j], j + 1);
        check("sz3_vld_g0", o_dt_vld, 1);
        check("sz3_last_g0", o_blk_last, 0);
        send_beats(124, 0);
        check("sz3_vld_g31", o_dt_vld, 1);
        check("sz3_last_g31", o_blk_last, 1);

        // Beats without start while idle are dropped.
        pulse_cnt = 0;
        send_beats(8, 1);
        check("idle_pulses", pulse_cnt, 0);

        // 4x4: upper lanes are forced to zero.
        for (int k = 0; k < 4; k++) begin
            d = rnd_beat();
            for (int n = 4; n < 8; n++) d[28*n +: 28] = 28'hFFFFFFF;
            step(1'b1, k == 0, 1'b1, 2'd0, d);
        end
        for (int j = 0; j < 32; j++)
            if ((j % 8) >= 4) check($sformatf("sz0_zero_%0d", j), dut_slot[j], 0);
        check("sz0_last", o_blk_last, 1);
        check("sz0_inv", o_inverse, 1);

        // 16x16 with random gaps: exactly eight groups, last flag only on the eighth.
        pulse_cnt = 0; last_cnt = 0;
        step(1'b1, 1'b1, 1'b0, 2'd2, rnd_beat());
        send_beats(31, 3);
        check("sz2_pulses", pulse_cnt, 8);
        check("sz2_lasts", last_cnt, 1);
        check("sz2_last_final", o_blk_last, 1);

        // Restart at group 5 beat 2 with a new size.
        step(1'b1, 1'b1, 1'b1, 2'd3, rnd_beat());
        send_beats(21, 0);
        pulse_cnt = 0;
        step(1'b1, 1'b1, 1'b0, 2'd1, rnd_beat());
        check("restart_err", o_err, 1);
        send_beats(3, 0);
        check("restart_pulses", pulse_cnt, 1);
        check("restart_size", o_transize, 1);
        send_beats(4, 0);
        check("restart_last", o_blk_last, 1);

        // Back-to-back 8x8 blocks.
        pulse_cnt = 0; last_cnt = 0; err_cnt = 0;
        for (int b = 0; b < 2; b++) begin
            step(1'b1, 1'b1, 1'(b), 2'd1, rnd_beat());
            send_beats(7, 0);
        end
        check("b2b_pulses", pulse_cnt, 4);
        check("b2b_lasts", last_cnt, 2);
        check("b2b_errs", err_cnt, 0);

        // Random stream: gaps, sizes, modes and occasional restarts.
        for (int i = 0; i < 600; i++) begin
            logic v, s;
            v = ($urandom_range(3) != 0);
            s = m_active ? ($urandom_range(29) == 0) : ($urandom_range(2) == 0);
            step(v, s, 1'($urandom_range(1)), 2'($urandom_range(3)), rnd_beat());
        end

        // Reset mid-group: outputs clear at once and the partial group never appears.
        step(1'b1, 1'b1, 1'b1, 2'd3, rnd_beat());
        send_beats(2, 0);
        rst = 1'b1;
        #2;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;
        pulse_cnt = 0;
        send_beats(6, 0);
        check("post_rst_pulses", pulse_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
